// File: rtl/irq_ctrl.sv
// irq_ctrl - prioritizing interrupt controller in front of the core.
//
// Each asynchronous request line is synchronized, and its rising edges are
// latched into a pending register. A software-writable enable mask selects
// which pending sources may compete. The lowest-index eligible source is
// presented to the core through a request / ack / end-of-interrupt handshake.
// Only one interrupt is in flight at a time.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   irq_in      asynchronous interrupt lines, active high, edge-triggered
//   en_we       enable-mask write strobe
//   en_wd       new enable-mask value
//   en_q        current enable mask (register output)
//   pend_q      current pending register (register output)
//   int_req     interrupt request to the core
//   int_id      index of the requested / in-service source
//   ack         core accepts the request (1-cycle pulse)
//   eoi         core finished servicing (1-cycle pulse)
//   in_service  high from ack to eoi
module irq_ctrl #(
  parameter int               N_INT    = 4,
  parameter int               ID_W     = 2,
  parameter logic [N_INT-1:0] EN_RESET = {N_INT{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INT-1:0] irq_in,
  input  logic             en_we,
  input  logic [N_INT-1:0] en_wd,
  output logic [N_INT-1:0] en_q,
  output logic [N_INT-1:0] pend_q,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  input  logic             ack,
  input  logic             eoi,
  output logic             in_service
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_INT-1:0] s1_q, s1_d;
  logic [N_INT-1:0] s2_q, s2_d;
  logic [N_INT-1:0] s2_dly_q, s2_dly_d;
  logic [N_INT-1:0] pend_d;
  logic [N_INT-1:0] en_d;
  logic             int_req_q, int_req_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;
  logic             in_service_q, in_service_d;

  logic [N_INT-1:0] rise;
  logic [N_INT-1:0] eligible;
  logic [N_INT-1:0] clr_mask;
  logic [ID_W-1:0]  winner;
  logic             ack_take;

  // An ack only counts while a request is outstanding.
  assign ack_take = (state_q == REQ) && ack;

  // Per-source clear: only the bit of the acknowledged source is cleared.
  generate
    for (genvar gi = 0; gi < N_INT; gi++) begin : g_clr
      assign clr_mask[gi] = ack_take && (int_id_q == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    s1_d     = irq_in;
    s2_d     = s1_q;
    s2_dly_d = s2_q;
    rise     = s2_q & ~s2_dly_q;
    eligible = pend_q & en_q;

    // Scan from the top so the lowest set index is the last one written.
    winner = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end

    // A new edge on a bit being cleared wins, so the edge is not lost.
    pend_d = (pend_q & ~clr_mask) | rise;
    en_d   = en_we ? en_wd : en_q;

    state_d      = state_q;
    int_req_d    = int_req_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          int_id_d  = winner;
          int_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // The request is committed; eoi here is ignored.
        if (ack) begin
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = SVC;
        end
      end
      SVC: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s2_dly_q     <= '0;
      pend_q       <= '0;
      en_q         <= EN_RESET;
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s2_dly_q     <= s2_dly_d;
      pend_q       <= pend_d;
      en_q         <= en_d;
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic         en_we = 1'b0;
  logic [N-1:0] en_wd = '0;
  logic [N-1:0] en_q;
  logic [N-1:0] pend_q;
  logic         int_req;
  logic [1:0]   int_id;
  logic         ack = 1'b0;
  logic         eoi = 1'b0;
  logic         in_service;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.N_INT(N), .ID_W(2), .EN_RESET(4'b1111)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .en_we(en_we), .en_wd(en_wd),
    .en_q(en_q), .pend_q(pend_q), .int_req(int_req), .int_id(int_id),
    .ack(ack), .eoi(eoi), .in_service(in_service)
  );

  // Reference model: line sample history, pending/enable sets and a
  // transaction view (request outstanding, source being serviced).
  logic [N-1:0] h1, h2, h3;   // irq_in sampled 1, 2, 3 edges ago
  logic [N-1:0] m_pend, m_en;
  logic         m_req, m_svc;
  logic [1:0]   m_id;

  task automatic model_edge();
    logic [N-1:0] rise, elig, clr;
    if (rst) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_pend = '0; m_en = 4'b1111;
      m_req = 1'b0; m_svc = 1'b0; m_id = '0;
    end else begin
      // Edge n sees a rising edge when the line was high 2 edges ago and
      // low 3 edges ago.
      rise = h2 & ~h3;
      elig = m_pend & m_en;
      clr  = '0;
      if (m_req) begin
        if (ack) begin
          clr = 4'b0001 << m_id;
          m_req = 1'b0;
          m_svc = 1'b1;
        end
      end else if (m_svc) begin
        if (eoi) m_svc = 1'b0;
      end else if (elig != 0) begin
        for (int i = 0; i < N; i++) begin
          if (elig[i]) begin
            m_id = 2'(i);
            break;
          end
        end
        m_req = 1'b1;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (en_we) m_en = en_wd;
      h3 = h2; h2 = h1; h1 = irq_in;
    end
  endtask

  // Advance one clock: the model evaluates at the edge with the inputs the
  // DUT samples, then the bench returns on the falling edge to check.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++;
    if ({int_req, in_service, int_id, pend_q, en_q} !== {1'b0, 1'b0, 2'd0, 4'd0, 4'b1111}) begin
      n_err++;
      $display("FAIL reset: req=%b svc=%b id=%0d pend=%b en=%b, want 0 0 0 0000 1111",
               int_req, in_service, int_id, pend_q, en_q);
    end
    rst = 1'b0;
    step(); step();
    $display("test_reset done");
  endtask

  task automatic test_single();
    irq_in = 4'b0100;
    step(); step(); step();          // edges 1..3
    irq_in = '0;
    n_cmp++;
    if (pend_q !== 4'b0100 || int_req !== 1'b0) begin
      n_err++;
      $display("FAIL single_pend: pend=%b req=%b, want 0100 0", pend_q, int_req);
    end
    step();                          // edge 4
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd2) begin
      n_err++;
      $display("FAIL single_req: req=%b id=%0d, want 1 2", int_req, int_id);
    end
    ack = 1'b1; step(); ack = 1'b0;
    n_cmp++;
    if (int_req !== 1'b0 || in_service !== 1'b1 || pend_q !== 4'b0000) begin
      n_err++;
      $display("FAIL single_ack: req=%b svc=%b pend=%b, want 0 1 0000", int_req, in_service, pend_q);
    end
    eoi = 1'b1; step(); eoi = 1'b0;
    n_cmp++;
    if (in_service !== 1'b0 || int_req !== 1'b0) begin
      n_err++;
      $display("FAIL single_eoi: svc=%b req=%b, want 0 0", in_service, int_req);
    end
    $display("test_single done");
  endtask

  task automatic test_priority();
    irq_in = 4'b1010;
    step(); step(); step();
    irq_in = '0;
    step();
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd1) begin
      n_err++;
      $display("FAIL prio_first: req=%b id=%0d, want 1 1", int_req, int_id);
    end
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    n_cmp++;
    if (int_req !== 1'b0 || pend_q !== 4'b1000) begin
      n_err++;
      $display("FAIL prio_gap: req=%b pend=%b, want 0 1000", int_req, pend_q);
    end
    step();
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd3) begin
      n_err++;
      $display("FAIL prio_second: req=%b id=%0d, want 1 3", int_req, int_id);
    end
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    $display("test_priority done");
  endtask

  task automatic test_masking();
    en_we = 1'b1; en_wd = 4'b1110; step(); en_we = 1'b0;
    irq_in = 4'b0001;
    step(); step(); step();
    irq_in = '0;
    step(); step();
    n_cmp++;
    if (pend_q !== 4'b0001 || int_req !== 1'b0 || en_q !== 4'b1110) begin
      n_err++;
      $display("FAIL mask_hold: pend=%b req=%b en=%b, want 0001 0 1110", pend_q, int_req, en_q);
    end
    en_we = 1'b1; en_wd = 4'b1111; step(); en_we = 1'b0;
    n_cmp++;
    if (int_req !== 1'b0) begin
      n_err++;
      $display("FAIL mask_write_edge: req=%b, want 0", int_req);
    end
    step();
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd0) begin
      n_err++;
      $display("FAIL mask_unmask: req=%b id=%0d, want 1 0", int_req, int_id);
    end
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    $display("test_masking done");
  endtask

  task automatic test_committed();
    irq_in = 4'b0100;
    step(); step(); step();
    irq_in = '0;
    step();                          // REQ with id 2
    en_we = 1'b1; en_wd = 4'b1011; irq_in = 4'b0001;
    step();
    en_we = 1'b0;
    step(); step();
    irq_in = '0;
    step(); step();
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd2 || pend_q !== 4'b0101) begin
      n_err++;
      $display("FAIL commit_hold: req=%b id=%0d pend=%b, want 1 2 0101", int_req, int_id, pend_q);
    end
    eoi = 1'b1; ack = 1'b1; step(); eoi = 1'b0; ack = 1'b0;
    n_cmp++;
    if (in_service !== 1'b1 || pend_q !== 4'b0001) begin
      n_err++;
      $display("FAIL commit_ack_eoi: svc=%b pend=%b, want 1 0001", in_service, pend_q);
    end
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd0) begin
      n_err++;
      $display("FAIL commit_next: req=%b id=%0d, want 1 0", int_req, int_id);
    end
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; en_we = 1'b1; en_wd = 4'b1111; step(); eoi = 1'b0; en_we = 1'b0;
    $display("test_committed done");
  endtask

  task automatic test_set_clear();
    logic [N-1:0] seq [7];
    seq = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    for (int e = 0; e < 7; e++) begin
      irq_in = seq[e];
      ack = (e == 6);                // edge 7: ack meets the second rise
      step();
      if (e == 3) begin
        n_cmp++;
        if (int_req !== 1'b1 || int_id !== 2'd1) begin
          n_err++;
          $display("FAIL setclr_req: req=%b id=%0d, want 1 1", int_req, int_id);
        end
      end
    end
    ack = 1'b0;
    n_cmp++;
    if (pend_q !== 4'b0010 || in_service !== 1'b1) begin
      n_err++;
      $display("FAIL setclr_pend: pend=%b svc=%b, want 0010 1", pend_q, in_service);
    end
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    $display("test_set_clear done");
  endtask

  task automatic test_reset_mid();
    en_we = 1'b1; en_wd = 4'b0111; step(); en_we = 1'b0;
    irq_in = 4'b0100;
    step(); step(); step();
    irq_in = '0;
    step();
    ack = 1'b1; step(); ack = 1'b0;  // now in SVC
    irq_in = 4'b0001;
    rst = 1'b1;
    step(); step();
    n_cmp++;
    if ({int_req, in_service, int_id, pend_q, en_q} !== {1'b0, 1'b0, 2'd0, 4'd0, 4'b1111}) begin
      n_err++;
      $display("FAIL rstmid_vals: req=%b svc=%b id=%0d pend=%b en=%b, want 0 0 0 0000 1111",
               int_req, in_service, int_id, pend_q, en_q);
    end
    rst = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (int_req !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_early: req=%b, want 0 at edge 3", int_req);
    end
    step();
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd0) begin
      n_err++;
      $display("FAIL rstmid_held: req=%b id=%0d, want 1 0", int_req, int_id);
    end
    irq_in = '0;
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic was_req;
    for (int c = 0; c < 1500; c++) begin
      if (c % 2 == 0)
        irq_in = irq_in ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rst   = ($urandom_range(0, 299) == 0);
      en_we = ($urandom_range(0, 15) == 0);
      en_wd = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      ack   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      eoi   = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      was_req = m_req && ack && !rst;
      step();
      n_cmp++;
      if (int_req !== m_req || in_service !== m_svc || int_id !== m_id ||
          pend_q !== m_pend || en_q !== m_en) begin
        n_err++;
        $display("FAIL random_c%0d: req=%b svc=%b id=%0d pend=%b en=%b, want %b %b %0d %b %b",
                 c, int_req, in_service, int_id, pend_q, en_q, m_req, m_svc, m_id, m_pend, m_en);
      end
      if (was_req) $display("txn ack id=%0d cycle=%0d", m_id, c);
    end
    rst = 1'b0; ack = 1'b0; eoi = 1'b0; en_we = 1'b0;
  endtask

  initial begin
    h1 = '0; h2 = '0; h3 = '0;
    m_pend = '0; m_en = 4'b1111; m_req = 1'b0; m_svc = 1'b0; m_id = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_committed();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Prioritizing interrupt controller between the external interrupt lines of the SoC and the `mips_top` core. It synchronizes asynchronous request lines, latches rising edges as pending, applies a software-writable enable mask and picks the highest-priority pending source. It presents that source to the core with a request/acknowledge/end-of-interrupt handshake. Only one interrupt is in flight at a time; nesting is not supported.

## Interface

Parameters:
- `N_INT`, default 4: number of interrupt sources, 2..16.
- `ID_W`, default 2: width of `int_id`, equal to clog2(`N_INT`).
- `EN_RESET`, default {N_INT{1'b1}}: reset value of the enable mask.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_in`  in  N_INT  asynchronous interrupt lines, active high, edge-triggered.
- `en_we`  in  1  write strobe for the enable mask.
- `en_wd`  in  N_INT  new enable mask value.
- `en_q`  out  N_INT  current enable mask.
- `pend_q`  out  N_INT  current pending register.
- `int_req`  out  1  interrupt request to the core.
- `int_id`  out  ID_W  index of the requested or in-service source.
- `ack`  in  1  core accepts the request (1-cycle pulse).
- `eoi`  in  1  core finished servicing (1-cycle pulse).
- `in_service`  out  1  high from `ack` to `eoi`.

## Operation

- **Synchronizer.** Each `irq_in` bit passes through a 2-flop synchronizer to `s2`. A 1-flop delayed copy of `s2` gives `s2_d`.
- **Edge detect.** `rise = s2 & ~s2_d`. This logic is combinational.
- **Pending set.** `pend[i]` sets on `rise[i]`, whether or not the source is enabled. A masked source therefore stays pending and fires when it is enabled.
- **Pending clear.** `pend[int_id]` clears on `ack` in state REQ. If `rise[i]` and that clear hit the same bit in the same cycle, the set wins.
- **Eligibility.** A source is eligible when `pend & en_q` is nonzero. Priority is fixed: the lowest index wins.
- **Enable mask.** `en_q <= en_wd` on `en_we`. The new value takes effect for arbitration on the next cycle.
- **FSM, state IDLE.** If any source is eligible: latch `int_id` = winner, set `int_req`=1, go to REQ.
- **FSM, state REQ.**
  - `int_req` and `int_id` are held stable. The request is committed: masking or new higher-priority edges do not withdraw or change it.
  - On `ack`: clear the pending bit, `int_req`=0, `in_service`=1, go to SVC.
  - `eoi` in REQ is ignored, including when it arrives with `ack` in the same cycle.
- **FSM, state SVC.**
  - `int_id` is held.
  - New edges latch into `pend`.
  - On `eoi`: `in_service`=0, go to IDLE.
  - `ack` in SVC is ignored.
- **Ignored inputs.** `ack` and `eoi` in IDLE are ignored.
- **Reset values.** `rst` clears the synchronizer flops, `s2_d`, `pend`, `int_req`, `in_service`, `int_id`=0 and state IDLE, and sets `en_q`=EN_RESET.
- **Reset mid-operation.** An in-flight request is dropped with no pending bit kept.
- **Line high through reset release.** A line held high across reset release is seen as a rising edge after release, because the synchronizer resets to 0.

## Timing

- **Edge-to-request latency.** Number the first rising edge that samples `irq_in[i]`=1 as edge 1:
  - `s1` at edge 1;
  - `s2` at edge 2;
  - `pend[i]` at edge 3;
  - `int_req`=1 and `int_id`=i at edge 4.
- **Pulse width.** Input pulses shorter than 1 clk period may be missed. The pulse width requirement is at least 2 clk periods.
- **Ack.** `ack` sampled high at edge k gives `int_req`=0, `in_service`=1 and `pend[int_id]`=0 after edge k.
- **End of interrupt.** `eoi` at edge k gives `in_service`=0 and IDLE after edge k. If another source is eligible, `int_req` rises at edge k+1, so the minimum gap between requests is 1 cycle.
- **Mask write.** An `en_we` at edge k affects winner selection from edge k+1.
- **Outputs.** All outputs are registered. `en_q` and `pend_q` are direct register outputs.

## Test plan

- **Single interrupt.** Reset, then `irq_in`=4'b0100 held for 3 cycles → `int_req`=1 with `int_id`=2 at edge 4. Then `ack` → `int_req`=0, `in_service`=1, `pend_q`=0. Then `eoi` → `in_service`=0.
- **Priority.** Edges on bits 3 and 1 in the same cycle → `int_id`=1 first. After `ack`/`eoi`, `int_req` rises 1 cycle later with `int_id`=3.
- **Masking.** `en_wd`=4'b1110 written, then an edge on bit 0 → `pend_q`=4'b0001 and `int_req` stays 0. Writing `en_wd`=4'b1111 → `int_req`=1 with `int_id`=0 two edges after the write.
- **Committed request.** In REQ with `int_id`=2, an edge arrives on bit 0 and bit 2 is masked → `int_id` stays 2 until `ack`. After `eoi`, `int_id`=0.
- **Simultaneous set and clear.** `ack` for id 1 in the same cycle as a new `rise[1]` → `pend_q[1]`=1 afterwards.
- **Reset mid-operation and held line.** `rst` asserted in SVC → all outputs return to reset values and `en_q`=4'b1111. With `irq_in[0]` held high through `rst` release → `int_req` rises with `int_id`=0 at the 4th edge after release.
